// File: rtl/cache_trace_monitor.sv
// cache_trace_monitor: timestamped circular trace of L1 cache controller events
// (access, eviction, FSM state change), with saturating hit/miss/evict
// counters, sticky overflow and one-hot error flags, and a pop port.
module cache_trace_monitor #(
    parameter int NUM_WAYS = 4,
    parameter int ADDR_W   = 32,
    parameter int STATE_W  = 4,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 32,
    localparam int WAY_W   = $clog2(NUM_WAYS),
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int E       = 16 + STATE_W + 3 + WAY_W + ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                mode_wrap,
    input  logic [STATE_W-1:0]  fsm_state,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                hit,
    input  logic [NUM_WAYS-1:0] way_sel,
    input  logic                evict_valid,
    input  logic                rd_req,
    output logic                rd_valid,
    output logic [E-1:0]        rd_data,
    output logic [PTR_W:0]      count,
    output logic                overflow,
    output logic                onehot_err,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt,
    output logic [CNT_W-1:0]    evict_cnt
);

    // Index of the lowest set bit; zero when no bit is set.
    function automatic logic [WAY_W-1:0] lowest_way(input logic [NUM_WAYS-1:0] w);
        lowest_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (w[i]) lowest_way = WAY_W'(i);
        end
    endfunction

    // Exactly one bit set.
    function automatic logic is_onehot(input logic [NUM_WAYS-1:0] w);
        is_onehot = (w != '0) && ((w & (w - NUM_WAYS'(1))) == '0);
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [15:0]        tstamp;
    logic [STATE_W-1:0] prev_state;
    logic               prev_ok;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [E-1:0]       mem [DEPTH];

    logic               full;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic               push_lost;
    logic               wrap_adv;
    logic [E-1:0]       entry;

    // Push/pop decode; a full buffer with a simultaneous pop always accepts the push.
    always_comb begin
        full      = (count == (PTR_W + 1)'(DEPTH));
        pop       = rd_req && (count != '0) && !clear;
        push      = prev_ok && !clear &&
                    (req_valid || evict_valid || (fsm_state != prev_state));
        wr_en     = push && (!full || pop || mode_wrap);
        push_lost = push && full && !pop;
        wrap_adv  = push_lost && mode_wrap;
        entry     = {tstamp, fsm_state, req_write, hit, evict_valid,
                     lowest_way(way_sel), req_addr};
    end

    // Previous FSM state; the first edge after reset only primes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state <= '0;
            prev_ok    <= 1'b0;
        end else begin
            prev_state <= fsm_state;
            prev_ok    <= 1'b1;
        end
    end

    // Trace storage; unreachable contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= entry;
    end

    // Pointers, occupancy, read port, timestamp, counters and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstamp     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            overflow   <= 1'b0;
            onehot_err <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            evict_cnt  <= '0;
        end else if (clear) begin
            tstamp     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            overflow   <= 1'b0;
            onehot_err <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            evict_cnt  <= '0;
        end else begin
            tstamp   <= tstamp + 16'd1;
            rd_valid <= pop;
            if (pop) rd_data <= mem[rd_ptr];
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop || wrap_adv) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !full && !pop)      count <= count + (PTR_W + 1)'(1);
            else if (pop && !push)          count <= count - (PTR_W + 1)'(1);
            if (push_lost) overflow <= 1'b1;
            if (req_valid && hit)  hit_cnt   <= sat_inc(hit_cnt);
            if (req_valid && !hit) miss_cnt  <= sat_inc(miss_cnt);
            if (evict_valid)       evict_cnt <= sat_inc(evict_cnt);
            if (req_valid && hit && !is_onehot(way_sel)) onehot_err <= 1'b1;
        end
    end

endmodule

// File: doc/cache_trace_monitor.md
# cache_trace_monitor

Synthesizable trace and statistics block for the L1 cache controller. It sits beside the cache top level and observes the controller FSM state, way select, hit/miss and eviction strobes. Each qualifying event is recorded as a timestamped entry in a circular trace buffer. It also maintains saturating hit, miss and eviction counters, so the simulation-only waveform probing can be replaced with something that runs in silicon/FPGA and is readable through a pop port.

## Interface
- NUM_WAYS, 4, associativity; width of way_sel (power of 2, ≥2)
- ADDR_W, 32, request address width
- STATE_W, 4, controller FSM state width
- DEPTH, 16, trace entries (power of 2, ≥2)
- CNT_W, 32, event counter width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of buffer, counters, timestamp, sticky flags
- mode_wrap  in  1  1: overwrite oldest when full; 0: drop new when full
- fsm_state  in  STATE_W  controller state
- req_valid  in  1  cache access resolved this cycle
- req_write  in  1  access is a write
- req_addr  in  ADDR_W  access address
- hit  in  1  access hit (qualified by req_valid)
- way_sel  in  NUM_WAYS  one-hot way of hit/fill
- evict_valid  in  1  dirty line eviction issued
- rd_req  in  1  pop oldest entry
- rd_valid  out  1  rd_data valid
- rd_data  out  E  entry, E = 16+STATE_W+3+log2(NUM_WAYS)+ADDR_W
- count  out  log2(DEPTH)+1  entries held
- overflow  out  1  sticky: an entry was dropped or overwritten
- onehot_err  out  1  sticky: way_sel not one-hot on a hit
- hit_cnt, miss_cnt, evict_cnt  out  CNT_W  saturating event counters

## Operation
- Entry packing, MSB→LSB: {tstamp[15:0], fsm_state, req_write, hit, evict_valid, way_idx, req_addr}.
- way_idx = index of lowest set bit of way_sel; 0 if way_sel is zero.
- Capture condition (push): req_valid OR evict_valid OR fsm_state ≠ registered previous state.
  - Previous state is initialised at reset to the value sampled on the first clock edge after reset.
  - No push occurs on that first edge.
- At most one push per cycle; all simultaneous events share one entry.
- tstamp: free-running 16-bit cycle counter, wraps 0xFFFF→0.
- Counters:
  - hit_cnt increments on req_valid&hit.
  - miss_cnt increments on req_valid&!hit.
  - evict_cnt increments on evict_valid.
  - Each counter saturates at all-ones.
- onehot_err sets on req_valid&hit with way_sel not exactly one-hot.
- Buffer: read pointer, write pointer, count. Pointers wrap modulo DEPTH.
- Full with push and no pop:
  - mode_wrap=1: overwrite oldest, advance both pointers, set overflow.
  - mode_wrap=0: discard entry, set overflow.
- Full with push and pop: pop returns oldest; push written; count stays DEPTH; no overflow in either mode.
- Empty with push and pop: pop ignored (rd_valid=0); push accepted, count=1.
- rd_req while empty: ignored, no state change.
- clear: empties buffer, zeroes counters, tstamp, overflow, onehot_err. Same-cycle events are not recorded or counted. A clear-cycle rd_req returns rd_valid=0.
- mode_wrap may change at any time; it takes effect on the next push-when-full.

## Timing
- Reset values: rd_valid=0, rd_data=0, count=0, overflow=0, onehot_err=0, all counters=0, tstamp=0, pointers=0.
- Push latency: event in cycle N is written at edge ending N. count reflects it in cycle N+1. The entry's tstamp is the value during cycle N.
- Counters and sticky flags update at the edge ending the event cycle.
- Pop: rd_req in cycle N → rd_valid=1 and rd_data in cycle N+1 only. rd_valid is a one-cycle pulse per accepted pop. rd_data holds its last value otherwise.
- Back-to-back rd_req pops one entry per cycle.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Buffer contents need not be cleared, but they are unreachable because count=0.

## Test plan
- Reset then 3 accesses (hit way2 addr 0x100, miss addr 0x200, write hit way0 addr 0x300), no state change → count=3; hit_cnt=2, miss_cnt=1; pops return those addrs in order with way_idx 2, 0, 0 and consecutive-cycle tstamps.
- fsm_state 0→1 with req_valid and evict_valid in the same cycle → one entry, state=1, evict bit=1; evict_cnt=1.
- mode_wrap=0, 20 pushes, DEPTH=16 → count=16, overflow=1, pops return pushes 0-15. Repeat with mode_wrap=1 → pops return pushes 4-19.
- Full buffer, push+pop same cycle → count stays 16, overflow stays 0, popped entry is the oldest.
- rd_req on empty → rd_valid=0. hit with way_sel=4'b0110 → onehot_err=1, way_idx=1. clear → all outputs zero next cycle.
- CNT_W=4: 17 hits → hit_cnt=15 (saturated). Assert rst_n low mid-pop → rd_valid=0 and count=0 immediately.
